// File: rtl/n64_vmux.sv
// N64 VI digital video bus transmitter: serializes sync/R/G/B pixel groups onto nDSYNC_o/D_o.
// Define N64_VMUX_BLURGROUP_EN to add blur_en_i (each accepted pixel sent in two groups).
module n64_vmux #(
    parameter int color_width = 7
) (
    input  logic                   nCLK,
    input  logic                   nRST,
    input  logic                   pix_valid_i,
    output logic                   pix_ready_o,
    input  logic [3:0]             pix_sync_i,
    input  logic [color_width-1:0] pix_r_i,
    input  logic [color_width-1:0] pix_g_i,
    input  logic [color_width-1:0] pix_b_i,
    input  logic                   n15bit_mode_i,
`ifdef N64_VMUX_BLURGROUP_EN
    input  logic                   blur_en_i,
`endif
    output logic                   nDSYNC_o,
    output logic [color_width-1:0] D_o,
    output logic                   underflow_o
);

    localparam logic [1:0] PH_SYNC = 2'd0;
    localparam logic [1:0] PH_R    = 2'd1;
    localparam logic [1:0] PH_G    = 2'd2;
    localparam logic [1:0] PH_B    = 2'd3;

    logic [1:0]             r_ph;
    logic [3:0]             r_sync;
    logic [color_width-1:0] r_r;
    logic [color_width-1:0] r_g;
    logic [color_width-1:0] r_b;
    logic                   r_f15;
    logic                   r_ndsync;
    logic [color_width-1:0] r_d;
    logic                   r_uf;

    logic                   w_rep;
    logic                   w_group_start;
    logic                   w_accept;
    logic                   w_underflow;
    logic                   w_vs_fall;
    logic [3:0]             w_sync_nxt;
    logic                   w_ndsync_nxt;
    logic [color_width-1:0] w_d_nxt;

    function automatic logic [color_width-1:0] mask_c(input logic [color_width-1:0] c,
                                                      input logic f15);
        return f15 ? c : {c[color_width-1:2], 2'b00};
    endfunction

`ifdef N64_VMUX_BLURGROUP_EN
    logic r_rep;

    // Set for the first of the two groups; cleared at that group's end so the next ph==3 is eligible.
    always_ff @(posedge nCLK or negedge nRST) begin
        if (!nRST) begin
            r_rep <= 1'b0;
        end else if (w_accept) begin
            r_rep <= blur_en_i;
        end else if (w_group_start) begin
            r_rep <= 1'b0;
        end
    end

    assign w_rep = r_rep;
`else
    assign w_rep = 1'b0;
`endif

    assign w_group_start = (r_ph == PH_B);
    assign pix_ready_o   = w_group_start & ~w_rep;
    assign w_accept      = pix_ready_o & pix_valid_i;
    assign w_underflow   = pix_ready_o & ~pix_valid_i;
    assign w_sync_nxt    = w_accept ? pix_sync_i : r_sync;
    assign w_vs_fall     = w_group_start & r_sync[3] & ~w_sync_nxt[3];

    always_comb begin
        w_ndsync_nxt = 1'b1;
        w_d_nxt      = '0;
        case (r_ph)
            PH_B: begin
                w_ndsync_nxt = 1'b0;
                w_d_nxt      = {{(color_width-4){1'b0}}, w_sync_nxt};
            end
            PH_SYNC: w_d_nxt = mask_c(r_r, r_f15);
            PH_R:    w_d_nxt = mask_c(r_g, r_f15);
            PH_G:    w_d_nxt = mask_c(r_b, r_f15);
            default: w_d_nxt = '0;
        endcase
    end

    always_ff @(posedge nCLK or negedge nRST) begin
        if (!nRST) begin
            r_ph     <= PH_B;
            r_sync   <= 4'hF;
            r_r      <= '0;
            r_g      <= '0;
            r_b      <= '0;
            r_f15    <= 1'b1;
            r_ndsync <= 1'b1;
            r_d      <= '0;
            r_uf     <= 1'b0;
        end else begin
            r_ph     <= r_ph + 2'd1;
            r_ndsync <= w_ndsync_nxt;
            r_d      <= w_d_nxt;
            r_uf     <= w_underflow;
            if (w_accept) begin
                r_sync <= pix_sync_i;
                r_r    <= pix_r_i;
                r_g    <= pix_g_i;
                r_b    <= pix_b_i;
            end
            // Mode register updates at the group start; colour phases of this group already see it.
            if (w_vs_fall) begin
                r_f15 <= n15bit_mode_i;
            end
        end
    end

    assign nDSYNC_o    = r_ndsync;
    assign D_o         = r_d;
    assign underflow_o = r_uf;

endmodule

// File: tb/tb_n64_vmux.sv
// Scoreboard bench for n64_vmux: driver pushes per-cycle expected bus words, monitor pops and compares.
module tb_n64_vmux;

    logic       nCLK = 1'b0;
    logic       nRST;
    logic       pix_valid_i;
    logic       pix_ready_o;
    logic [3:0] pix_sync_i;
    logic [6:0] pix_r_i, pix_g_i, pix_b_i;
    logic       n15bit_mode_i;
    logic       blur_en_i;
    logic       nDSYNC_o;
    logic [6:0] D_o;
    logic       underflow_o;

    typedef struct {
        logic [9:0] w;     // {ready, nDSYNC, D, underflow}
        int         grp;
        int         idx;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 nCLK = ~nCLK;

    n64_vmux #(.color_width(7)) dut (
        .nCLK          (nCLK),
        .nRST          (nRST),
        .pix_valid_i   (pix_valid_i),
        .pix_ready_o   (pix_ready_o),
        .pix_sync_i    (pix_sync_i),
        .pix_r_i       (pix_r_i),
        .pix_g_i       (pix_g_i),
        .pix_b_i       (pix_b_i),
        .n15bit_mode_i (n15bit_mode_i),
`ifdef N64_VMUX_BLURGROUP_EN
        .blur_en_i     (blur_en_i),
`endif
        .nDSYNC_o      (nDSYNC_o),
        .D_o           (D_o),
        .underflow_o   (underflow_o)
    );

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got rdy=%b nds=%b D=%h uf=%b, want rdy=%b nds=%b D=%h uf=%b",
                      nm, act[9], act[8], act[7:1], act[0], exp[9], exp[8], exp[7:1], exp[0]);
    endtask

    // Apply one pixel (or underflow) at ph==3 and queue its expected bus words for ngrp groups.
    task automatic send(input int g, input logic v, input logic [3:0] s,
                        input logic [6:0] r, input logic [6:0] gg, input logic [6:0] b,
                        input logic m, input logic bl,
                        input logic [3:0] es, input logic [6:0] er, input logic [6:0] eg,
                        input logic [6:0] eb, input logic euf, input int ngrp, input int nexp);
        exp_t e;
        logic [6:0] d;
        pix_valid_i   = v;
        pix_sync_i    = s;
        pix_r_i       = r;
        pix_g_i       = gg;
        pix_b_i       = b;
        n15bit_mode_i = m;
        blur_en_i     = bl;
        for (int k = 0; k < nexp; k++) begin
            case (k % 4)
                0:       d = {3'b000, es};
                1:       d = er;
                2:       d = eg;
                default: d = eb;
            endcase
            e.w   = {(k == 4*ngrp-1), (k % 4 != 0), d, (euf && k == 0)};
            e.grp = g;
            e.idx = k;
            sb.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge nCLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("g%0d_c%0d", e.grp, e.idx),
                      {pix_ready_o, nDSYNC_o, D_o, underflow_o}, e.w);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: timeout, got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        nRST = 1'b0;
        pix_valid_i = 1'b0; pix_sync_i = 4'hF;
        pix_r_i = '0; pix_g_i = '0; pix_b_i = '0;
        n15bit_mode_i = 1'b1; blur_en_i = 1'b0;
        repeat (3) @(negedge nCLK);
        check("reset_state", {pix_ready_o, nDSYNC_o, D_o, underflow_o}, {1'b1, 1'b1, 7'h00, 1'b0});
        nRST = 1'b1;

        send(0, 1, 4'hF, 7'h55, 7'h2A, 7'h7F, 1, 0, 4'hF, 7'h55, 7'h2A, 7'h7F, 0, 1, 4);
        repeat (4) @(negedge nCLK);
        send(1, 1, 4'hF, 7'h11, 7'h22, 7'h33, 1, 0, 4'hF, 7'h11, 7'h22, 7'h33, 0, 1, 4);
        repeat (4) @(negedge nCLK);
        send(2, 0, 4'h0, 7'h00, 7'h00, 7'h00, 1, 0, 4'hF, 7'h11, 7'h22, 7'h33, 1, 1, 4);
        repeat (4) @(negedge nCLK);
        send(3, 1, 4'hE, 7'h01, 7'h02, 7'h03, 1, 0, 4'hE, 7'h01, 7'h02, 7'h03, 0, 1, 4);
        repeat (4) @(negedge nCLK);
        // 15-bit mode requested but no nVSYNC fall yet
        send(4, 1, 4'hF, 7'h7F, 7'h7F, 7'h03, 0, 0, 4'hF, 7'h7F, 7'h7F, 7'h03, 0, 1, 4);
        repeat (4) @(negedge nCLK);
        send(5, 1, 4'h7, 7'h7F, 7'h2B, 7'h03, 0, 0, 4'h7, 7'h7C, 7'h28, 7'h00, 0, 1, 4);
        repeat (4) @(negedge nCLK);
        send(6, 1, 4'h7, 7'h13, 7'h7F, 7'h7E, 1, 0, 4'h7, 7'h10, 7'h7C, 7'h7C, 0, 1, 4);
        repeat (4) @(negedge nCLK);
        send(7, 1, 4'hF, 7'h55, 7'h2A, 7'h7F, 1, 0, 4'hF, 7'h54, 7'h28, 7'h7C, 0, 1, 4);
        repeat (4) @(negedge nCLK);
        send(8, 1, 4'h7, 7'h7F, 7'h2B, 7'h03, 1, 0, 4'h7, 7'h7F, 7'h2B, 7'h03, 0, 1, 4);
        repeat (4) @(negedge nCLK);
        send(9, 0, 4'hF, 7'h00, 7'h00, 7'h00, 0, 0, 4'h7, 7'h7F, 7'h2B, 7'h03, 1, 1, 4);
        repeat (4) @(negedge nCLK);
        send(10, 1, 4'h7, 7'h55, 7'h2A, 7'h7F, 0, 0, 4'h7, 7'h55, 7'h2A, 7'h7F, 0, 1, 4);
        repeat (4) @(negedge nCLK);

        // Group truncated by reset during the R phase
        send(11, 1, 4'hF, 7'h31, 7'h32, 7'h33, 1, 0, 4'hF, 7'h31, 7'h32, 7'h33, 0, 1, 2);
        @(posedge nCLK);
        @(posedge nCLK);
        #2;
        nRST = 1'b0;
        #1;
        check("async_reset", {pix_ready_o, nDSYNC_o, D_o, underflow_o}, {1'b1, 1'b1, 7'h00, 1'b0});
        @(negedge nCLK);
        check("reset_hold", {pix_ready_o, nDSYNC_o, D_o, underflow_o}, {1'b1, 1'b1, 7'h00, 1'b0});
        nRST = 1'b1;
        send(12, 1, 4'hF, 7'h0A, 7'h0B, 7'h0C, 1, 0, 4'hF, 7'h0A, 7'h0B, 7'h0C, 0, 1, 4);
        repeat (4) @(negedge nCLK);
`ifdef N64_VMUX_BLURGROUP_EN
        send(13, 1, 4'hF, 7'h21, 7'h22, 7'h23, 1, 1, 4'hF, 7'h21, 7'h22, 7'h23, 0, 2, 8);
        repeat (8) @(negedge nCLK);
        send(14, 1, 4'hE, 7'h41, 7'h42, 7'h43, 1, 0, 4'hE, 7'h41, 7'h42, 7'h43, 0, 1, 4);
        repeat (4) @(negedge nCLK);
`endif
        pix_valid_i = 1'b0;
        repeat (2) @(negedge nCLK);
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
